// File: rtl/controlador_bomba.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module : controlador_bomba
// | Fill-pump sequencer: sensor sync/debounce, level + consistency decode,
// | pump FSM with hysteresis, min on/off times and dry-run timeout.
// | Rev    : 1.0
// +----------------------------------------------------------------------------
module controlador_bomba #(
  parameter int DEBOUNCE_CYC  = 16,
  parameter int MIN_ON_CYC    = 1000,
  parameter int MIN_OFF_CYC   = 1000,
  parameter int MAX_ON_CYC    = 50000,
  parameter int NIVEL_LIGA    = 1,
  parameter int NIVEL_DESLIGA = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sensores_in,
  input  logic       habilita,
  input  logic       limpa_falha,
  output logic [4:0] sensores_filt,
  output logic [2:0] nivel,
  output logic       bomba_on,
  output logic       alarme_falha,
  output logic [1:0] estado
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int ON_W  = $clog2(MIN_ON_CYC + 1);
  localparam int OFF_W = $clog2(MIN_OFF_CYC + 1);
  localparam int DRY_W = $clog2(MAX_ON_CYC + 1);

  typedef enum logic [1:0] {
    OCIOSO    = 2'b00,
    BOMBEANDO = 2'b01,
    PAUSA     = 2'b10,
    FALHA     = 2'b11
  } estado_t;

  logic [4:0]       sync1_q, sync2_q, filt_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic             sync_muda;

  assign sync_muda = (sync1_q != sync2_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 5'b11111;
      sync2_q   <= 5'b11111;
      filt_q    <= 5'b11111;
      deb_cnt_q <= '0;
    end else begin
      sync1_q <= sensores_in;
      sync2_q <= sync1_q;
      if (sync_muda)
        deb_cnt_q <= '0;
      else if (deb_cnt_q < DEB_W'(DEBOUNCE_CYC))
        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
      if (!sync_muda && deb_cnt_q >= DEB_W'(DEBOUNCE_CYC - 1))
        filt_q <= sync2_q;
    end
  end

  // Wet bits (inverted sensors) must form 0..0111 for a consistent reading.
  logic [4:0] molhado;
  logic [2:0] nivel_d, nivel_q;
  logic       incons_d, incons_q;

  assign molhado  = ~filt_q;
  assign incons_d = |(molhado & (molhado + 5'd1));

  always_comb begin
    nivel_d = 3'd0;
    for (int i = 0; i < 5; i++)
      if (molhado[i]) nivel_d = 3'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nivel_q  <= 3'd0;
      incons_q <= 1'b0;
    end else begin
      nivel_q  <= nivel_d;
      incons_q <= incons_d;
    end
  end

  estado_t          st_q, st_d;
  logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
  logic [OFF_W-1:0] off_cnt_q, off_cnt_d;
  logic [DRY_W-1:0] dry_q, dry_d;
  logic             bomba_q, alarme_q;

  always_comb begin
    st_d      = st_q;
    on_cnt_d  = '0;
    off_cnt_d = '0;
    dry_d     = '0;
    case (st_q)
      OCIOSO: begin
        if (incons_q)
          st_d = FALHA;
        else if (habilita && nivel_q <= 3'(NIVEL_LIGA))
          st_d = BOMBEANDO;
      end
      BOMBEANDO: begin
        if (incons_q || dry_q == DRY_W'(MAX_ON_CYC - 1))
          st_d = FALHA;
        else if (!habilita)
          st_d = PAUSA;
        else if (nivel_q >= 3'(NIVEL_DESLIGA) && on_cnt_q >= ON_W'(MIN_ON_CYC - 1))
          st_d = PAUSA;
      end
      PAUSA: begin
        if (incons_q)
          st_d = FALHA;
        else if (off_cnt_q == OFF_W'(MIN_OFF_CYC - 1))
          st_d = OCIOSO;
      end
      FALHA: begin
        if (limpa_falha && !incons_q)
          st_d = PAUSA;
      end
      default: st_d = st_q;
    endcase

    // Counters only advance while staying in their state; entry leaves them at 0.
    if (st_q == BOMBEANDO && st_d == BOMBEANDO) begin
      on_cnt_d = (on_cnt_q == ON_W'(MIN_ON_CYC)) ? on_cnt_q : on_cnt_q + ON_W'(1);
      if (nivel_d > nivel_q)
        dry_d = '0;
      else
        dry_d = (dry_q == DRY_W'(MAX_ON_CYC)) ? dry_q : dry_q + DRY_W'(1);
    end
    if (st_q == PAUSA && st_d == PAUSA)
      off_cnt_d = (off_cnt_q == OFF_W'(MIN_OFF_CYC)) ? off_cnt_q : off_cnt_q + OFF_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= OCIOSO;
      on_cnt_q  <= '0;
      off_cnt_q <= '0;
      dry_q     <= '0;
      bomba_q   <= 1'b0;
      alarme_q  <= 1'b0;
    end else begin
      st_q      <= st_d;
      on_cnt_q  <= on_cnt_d;
      off_cnt_q <= off_cnt_d;
      dry_q     <= dry_d;
      bomba_q   <= (st_d == BOMBEANDO);
      alarme_q  <= (st_d == FALHA);
    end
  end

  assign sensores_filt = filt_q;
  assign nivel         = nivel_q;
  assign bomba_on      = bomba_q;
  assign alarme_falha  = alarme_q;
  assign estado        = st_q;

endmodule
`default_nettype wire

// File: tb/tb_controlador_bomba.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module : tb_controlador_bomba
// | Directed scenarios plus random traffic against a cycle-stamped level model.
// | Rev    : 1.0
// +----------------------------------------------------------------------------
module tb_controlador_bomba;

  localparam int DEB = 4, MIN_ON = 8, MIN_OFF = 6, MAX_ON = 40, LIGA = 1, DESLIGA = 4;
  localparam int S_OCIOSO = 0, S_BOMB = 1, S_PAUSA = 2, S_FALHA = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] sensores_in;
  logic       habilita, limpa_falha;
  logic [4:0] sensores_filt;
  logic [2:0] nivel;
  logic       bomba_on, alarme_falha;
  logic [1:0] estado;

  controlador_bomba #(
    .DEBOUNCE_CYC(DEB), .MIN_ON_CYC(MIN_ON), .MIN_OFF_CYC(MIN_OFF),
    .MAX_ON_CYC(MAX_ON), .NIVEL_LIGA(LIGA), .NIVEL_DESLIGA(DESLIGA)
  ) dut (
    .clk(clk), .rst(rst), .sensores_in(sensores_in), .habilita(habilita),
    .limpa_falha(limpa_falha), .sensores_filt(sensores_filt), .nivel(nivel),
    .bomba_on(bomba_on), .alarme_falha(alarme_falha), .estado(estado)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [4:0] thermo [6] = '{5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};

  // Reference model: raw sample history, filtered vector, and edge timestamps.
  logic [4:0] hist [$];
  logic [4:0] m_filt;
  int         m_nivel, m_state, m_cyc, m_entry, m_prog;
  bit         m_incons;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int level_of(input logic [4:0] v);
    for (int i = 4; i >= 0; i--)
      if (v[i] == 1'b0) return i;
    return 0;
  endfunction

  function automatic bit is_thermo(input logic [4:0] v);
    foreach (thermo[i])
      if (thermo[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DEB + 1; i++) hist.push_back(5'b11111);
    m_filt = 5'b11111; m_nivel = 0; m_incons = 1'b0;
    m_state = S_OCIOSO; m_cyc = 0; m_entry = 0; m_prog = 0;
  endtask

  task automatic model_edge();
    int  nxt, nv, since_entry, since_prog;
    bit  all_eq;
    since_entry = m_cyc - m_entry - 1;
    since_prog  = m_cyc - m_prog - 1;
    nxt = m_state;
    if (m_state != S_FALHA && m_incons)
      nxt = S_FALHA;
    else if (m_state == S_OCIOSO) begin
      if (habilita && m_nivel <= LIGA) nxt = S_BOMB;
    end else if (m_state == S_BOMB) begin
      if (since_prog == MAX_ON - 1) nxt = S_FALHA;
      else if (!habilita) nxt = S_PAUSA;
      else if (m_nivel >= DESLIGA && since_entry >= MIN_ON - 1) nxt = S_PAUSA;
    end else if (m_state == S_PAUSA) begin
      if (since_entry == MIN_OFF - 1) nxt = S_OCIOSO;
    end else begin
      if (limpa_falha && !m_incons) nxt = S_PAUSA;
    end
    nv = level_of(m_filt);
    if (nxt != m_state) begin
      m_entry = m_cyc;
      m_prog  = m_cyc;
    end else if (nxt == S_BOMB && nv > m_nivel) begin
      m_prog = m_cyc;
    end
    m_state  = nxt;
    m_nivel  = nv;
    m_incons = !is_thermo(m_filt);
    all_eq = 1'b1;
    foreach (hist[i]) if (hist[i] != hist[0]) all_eq = 1'b0;
    if (all_eq) m_filt = hist[0];
    hist.push_back(sensores_in);
    void'(hist.pop_front());
    m_cyc++;
  endtask

  task automatic compare_all();
    chk("filt",   {3'b0, sensores_filt}, {3'b0, m_filt});
    chk("nivel",  {5'b0, nivel},         8'(m_nivel));
    chk("estado", {6'b0, estado},        8'(m_state));
    chk("bomba",  {7'b0, bomba_on},      {7'b0, m_state == S_BOMB});
    chk("alarme", {7'b0, alarme_falha},  {7'b0, m_state == S_FALHA});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run_until_off(output int on_cyc);
    on_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      if (!bomba_on) break;
      on_cyc++;
      step();
    end
  endtask

  task automatic run_until_state(input logic [1:0] s, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (estado == s) break;
      step();
    end
  endtask

  task automatic pulse_limpa();
    limpa_falha = 1'b1;
    step();
    limpa_falha = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; sensores_in = 5'b11111; habilita = 1'b0; limpa_falha = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_filt",   {3'b0, sensores_filt}, 8'h1f);
    chk("rst_nivel",  {5'b0, nivel},         8'd0);
    chk("rst_estado", {6'b0, estado},        8'd0);
    chk("rst_bomba",  {7'b0, bomba_on},      8'd0);
    chk("rst_alarme", {7'b0, alarme_falha},  8'd0);
    repeat (3) step();

    // 1. Bounce, then hold 11100
    for (int i = 0; i < 5; i++) begin
      sensores_in = (i % 2 == 1) ? 5'b11100 : 5'b11110;
      repeat (2) step();
    end
    sensores_in = 5'b11100;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(); n++;
      if (sensores_filt == 5'b11100) break;
    end
    chk("s1_latency", 8'(n), 8'd6);
    step();
    chk("s1_nivel", {5'b0, nivel}, 8'd1);

    // 2. Fill cycle stepping the level up to 4
    habilita = 1'b1;
    step();
    chk("s2_start", {7'b0, bomba_on}, 8'd1);
    sensores_in = 5'b11000; repeat (8) step();
    sensores_in = 5'b10000; repeat (8) step();
    sensores_in = 5'b00000;
    run_until_off(n);
    chk("s2_stop_state", {6'b0, estado}, 8'd2);
    chk("s2_stop_nivel", {5'b0, nivel},  8'd4);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (estado != 2'd2) break;
      step(); n++;
    end
    chk("s2_pausa_len", 8'(n), 8'd6);
    chk("s2_ocioso", {6'b0, estado}, 8'd0);

    // 3. Early full: level reaches 4 two cycles after the start
    habilita = 1'b0;
    sensores_in = 5'b11100; repeat (10) step();
    sensores_in = 5'b00000; repeat (4) step();
    habilita = 1'b1;
    step();
    chk("s3_start", {7'b0, bomba_on}, 8'd1);
    run_until_off(n);
    chk("s3_min_on", 8'(n), 8'd8);
    run_until_state(2'd0, 30);

    // 4. Dry run
    sensores_in = 5'b11100;
    for (int i = 0; i < 30 && !bomba_on; i++) step();
    chk("s4_start", {7'b0, bomba_on}, 8'd1);
    run_until_off(n);
    chk("s4_dry_len", 8'(n), 8'd40);
    chk("s4_falha",   {6'b0, estado},       8'd3);
    chk("s4_alarme",  {7'b0, alarme_falha}, 8'd1);
    pulse_limpa();
    chk("s4_clear", {6'b0, estado}, 8'd2);

    // 5. Inconsistent vector during pumping
    run_until_state(2'd1, 30);
    chk("s5_bomb", {6'b0, estado}, 8'd1);
    sensores_in = 5'b10101;
    run_until_state(2'd3, 30);
    chk("s5_falha", {6'b0, estado},   8'd3);
    chk("s5_bomba", {7'b0, bomba_on}, 8'd0);
    pulse_limpa();
    chk("s5_ignored", {6'b0, estado}, 8'd3);
    sensores_in = 5'b11100; repeat (10) step();
    pulse_limpa();
    chk("s5_clear", {6'b0, estado}, 8'd2);

    // 6. Asynchronous reset mid-pumping
    run_until_state(2'd1, 30);
    repeat (3) step();
    chk("s6_pre", {7'b0, bomba_on}, 8'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("s6_async_bomba",  {7'b0, bomba_on}, 8'd0);
    chk("s6_async_estado", {6'b0, estado},   8'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("s6_filt",   {3'b0, sensores_filt}, 8'h1f);
    chk("s6_estado", {6'b0, estado},        8'd0);
    repeat (5) step();

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 4) == 0) sensores_in = 5'($urandom);
        else                           sensores_in = thermo[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 49) == 0) habilita = ~habilita;
      limpa_falha = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
